// File: rtl/axi_lite_master_p_pkg.sv
// Shared types and constants for the AXI4-lite master bridge.
// State encoding, response codes and protection default.
package axi_lite_master_p_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DRAIN
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  localparam int TIMER_W = 16;

endpackage

// File: rtl/axi_resp_watchdog.sv
// Response-wait timer; expire fires on the last allowed cycle.
// A zero TIMEOUT disables expiry entirely.
module axi_resp_watchdog
  import axi_lite_master_p_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  input  logic resp,
  output logic expire
);

  localparam bit ENABLED = (TIMEOUT != 0);
  localparam logic [TIMER_W-1:0] LIMIT =
    ENABLED ? TIMER_W'(TIMEOUT - 1) : '0;

  logic [TIMER_W-1:0] count;
  logic               tick;

  assign tick   = ENABLED && en && !resp;
  assign expire = tick && (count == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/axi_lite_master_p.sv
// AXI4-lite master bridge from a simple CPU request port.
// Concurrent AW/W issue, registered responses, optional timeout.
module axi_lite_master_p
  import axi_lite_master_p_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int STRB_W  = DATA_W / 8,
  parameter int TIMEOUT = 0
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [2:0]        AWPROT,
  output logic              WVALID,
  input  logic              WREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  input  logic              BVALID,
  output logic              BREADY,
  input  logic [1:0]        BRESP,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [2:0]        ARPROT,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              M_access,
  output logic              ready_M,
  input  logic              M_rd0_wr1,
  input  logic [ADDR_W-1:0] M_addr,
  input  logic [2:0]        M_prot,
  input  logic [DATA_W-1:0] M_write_data,
  input  logic [STRB_W-1:0] M_write_strobe,
  output logic              resp_valid_M,
  output logic [DATA_W-1:0] read_data_M,
  output logic [1:0]        resp_M
);

  state_t state, next;

  logic              aw_done, w_done, drain_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        prot_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        resp_q;

  logic wd_clear, wd_resp, expire;

  assign wd_clear = !(state == WR_RESP || state == RD_RESP);
  assign wd_resp  = (state == WR_RESP) ? BVALID : RVALID;

  axi_resp_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk    (ACLK),
    .rst_n  (ARESETn),
    .clear  (wd_clear),
    .en     (!wd_clear),
    .resp   (wd_resp),
    .expire (expire)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= next;
  end

  always_comb begin
    next    = state;
    ready_M = 1'b0;
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    BREADY  = 1'b0;
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    unique case (state)
      IDLE: begin
        ready_M = 1'b1;
        if (M_access) next = M_rd0_wr1 ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        AWVALID = !aw_done;
        WVALID  = !w_done;
        if (aw_done && w_done) next = WR_RESP;
      end
      WR_RESP: begin
        BREADY = 1'b1;
        if (BVALID)      next = IDLE;
        else if (expire) next = DRAIN;
      end
      RD_REQ: begin
        ARVALID = 1'b1;
        if (ARREADY) next = RD_RESP;
      end
      RD_RESP: begin
        RREADY = 1'b1;
        if (RVALID)      next = IDLE;
        else if (expire) next = DRAIN;
      end
      DRAIN: begin
        BREADY = drain_wr;
        RREADY = !drain_wr;
        if (drain_wr ? BVALID : RVALID) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      drain_wr     <= 1'b0;
      addr_q       <= '0;
      prot_q       <= PROT_DEFAULT;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      resp_q       <= RESP_OKAY;
    end else begin
      resp_valid_q <= 1'b0;
      if (state == IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (M_access) begin
          addr_q  <= M_addr;
          prot_q  <= M_prot;
          wdata_q <= M_write_data;
          wstrb_q <= M_write_strobe;
        end
      end
      if (AWVALID && AWREADY) aw_done <= 1'b1;
      if (WVALID && WREADY)   w_done  <= 1'b1;
      // A response landing on the expiry cycle takes priority.
      if (state == WR_RESP && BVALID) begin
        resp_valid_q <= 1'b1;
        resp_q       <= BRESP;
      end else if (state == RD_RESP && RVALID) begin
        resp_valid_q <= 1'b1;
        resp_q       <= RRESP;
        rdata_q      <= RDATA;
      end else if (expire) begin
        resp_valid_q <= 1'b1;
        resp_q       <= RESP_DECERR;
        rdata_q      <= '0;
        drain_wr     <= (state == WR_RESP);
      end
    end
  end

  assign AWADDR       = addr_q;
  assign ARADDR       = addr_q;
  assign AWPROT       = prot_q;
  assign ARPROT       = prot_q;
  assign WDATA        = wdata_q;
  assign WSTRB        = wstrb_q;
  assign resp_valid_M = resp_valid_q;
  assign read_data_M  = rdata_q;
  assign resp_M       = resp_q;

endmodule

// File: tb/tb_axi_lite_master_p.sv
// Directed bench for axi_lite_master_p with an 8-cycle watchdog.
// The bench plays the AXI slave cycle by cycle.
module tb_axi_lite_master_p;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        M_access, ready_M, M_rd0_wr1;
  logic [31:0] M_addr, M_write_data;
  logic [2:0]  M_prot;
  logic [3:0]  M_write_strobe;
  logic        resp_valid_M;
  logic [31:0] read_data_M;
  logic [1:0]  resp_M;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;

  axi_lite_master_p #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .ACLK           (ACLK),
    .ARESETn        (ARESETn),
    .AWVALID        (AWVALID),
    .AWREADY        (AWREADY),
    .AWADDR         (AWADDR),
    .AWPROT         (AWPROT),
    .WVALID         (WVALID),
    .WREADY         (WREADY),
    .WDATA          (WDATA),
    .WSTRB          (WSTRB),
    .BVALID         (BVALID),
    .BREADY         (BREADY),
    .BRESP          (BRESP),
    .ARVALID        (ARVALID),
    .ARREADY        (ARREADY),
    .ARADDR         (ARADDR),
    .ARPROT         (ARPROT),
    .RVALID         (RVALID),
    .RREADY         (RREADY),
    .RDATA          (RDATA),
    .RRESP          (RRESP),
    .M_access       (M_access),
    .ready_M        (ready_M),
    .M_rd0_wr1      (M_rd0_wr1),
    .M_addr         (M_addr),
    .M_prot         (M_prot),
    .M_write_data   (M_write_data),
    .M_write_strobe (M_write_strobe),
    .resp_valid_M   (resp_valid_M),
    .read_data_M    (read_data_M),
    .resp_M         (resp_M)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (resp_valid_M === 1'b1) pulses++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic req(input logic wr,
                     input logic [31:0] a,
                     input logic [31:0] d);
    M_access       = 1'b1;
    M_rd0_wr1      = wr;
    M_addr         = a;
    M_write_data   = d;
    M_write_strobe = 4'hF;
    M_prot         = 3'b010;
    tick();
    M_access = 1'b0;
  endtask

  initial begin
    {AWREADY, WREADY, BVALID, ARREADY, RVALID} = '0;
    BRESP = 2'b00; RRESP = 2'b00; RDATA = '0;
    M_access = 1'b0; M_rd0_wr1 = 1'b0; M_addr = '0;
    M_prot = '0; M_write_data = '0; M_write_strobe = '0;

    tick(2);
    check("rst_awvalid", AWVALID, 0);
    check("rst_wvalid", WVALID, 0);
    check("rst_arvalid", ARVALID, 0);
    check("rst_bready", BREADY, 0);
    check("rst_rready", RREADY, 0);
    check("rst_ready", ready_M, 1);
    check("rst_rvld", resp_valid_M, 0);
    check("rst_rdata", read_data_M, 0);
    check("rst_resp", resp_M, 0);
    check("rst_awaddr", AWADDR, 0);
    check("rst_wstrb", WSTRB, 0);
    ARESETn = 1'b1;
    tick();

    // 1: zero-wait write, same-cycle AW/W
    p0 = pulses;
    AWREADY = 1'b1; WREADY = 1'b1;
    req(1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
    check("t1_awvalid", AWVALID, 1);
    check("t1_wvalid", WVALID, 1);
    check("t1_awaddr", AWADDR, 32'h1000);
    check("t1_wdata", WDATA, 32'hDEAD_BEEF);
    check("t1_wstrb", WSTRB, 4'hF);
    check("t1_awprot", AWPROT, 3'b010);
    check("t1_ready", ready_M, 0);
    tick();
    AWREADY = 1'b0; WREADY = 1'b0;
    check("t1_awdrop", AWVALID, 0);
    check("t1_wdrop", WVALID, 0);
    check("t1_bready0", BREADY, 0);
    tick();
    check("t1_bready", BREADY, 1);
    check("t1_early", resp_valid_M, 0);
    BVALID = 1'b1; BRESP = 2'b00;
    tick();
    BVALID = 1'b0;
    check("t1_pulse", resp_valid_M, 1);
    check("t1_resp", resp_M, 0);
    check("t1_ready1", ready_M, 1);
    tick();
    check("t1_pulse_end", resp_valid_M, 0);
    check("t1_npulse", pulses - p0, 1);

    // 2: W accepted two cycles before AW
    p0 = pulses;
    req(1'b1, 32'h0000_3000, 32'h5555_AAAA);
    WREADY = 1'b1;
    tick();
    WREADY = 1'b0;
    check("t2_wdrop", WVALID, 0);
    check("t2_awhold", AWVALID, 1);
    check("t2_awaddr_a", AWADDR, 32'h3000);
    tick();
    check("t2_awhold2", AWVALID, 1);
    check("t2_awaddr_b", AWADDR, 32'h3000);
    AWREADY = 1'b1;
    tick();
    AWREADY = 1'b0;
    check("t2_awdrop", AWVALID, 0);
    check("t2_bready0", BREADY, 0);
    tick();
    check("t2_bready", BREADY, 1);
    BVALID = 1'b1; BRESP = 2'b00;
    tick();
    BVALID = 1'b0;
    check("t2_pulse", resp_valid_M, 1);
    check("t2_resp", resp_M, 0);
    tick();
    check("t2_bready_end", BREADY, 0);
    tick();
    check("t2_npulse", pulses - p0, 1);

    // 3: read with slow AR and slow R, SLVERR
    p0 = pulses;
    req(1'b0, 32'h0000_2000, 32'h0);
    check("t3_arvalid", ARVALID, 1);
    check("t3_araddr", ARADDR, 32'h2000);
    tick(2);
    check("t3_arhold", ARVALID, 1);
    check("t3_araddr2", ARADDR, 32'h2000);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    check("t3_ardrop", ARVALID, 0);
    check("t3_rready", RREADY, 1);
    tick(4);
    check("t3_early", resp_valid_M, 0);
    RVALID = 1'b1; RDATA = 32'h1234_5678; RRESP = 2'b10;
    tick();
    RVALID = 1'b0;
    check("t3_pulse", resp_valid_M, 1);
    check("t3_rdata", read_data_M, 32'h1234_5678);
    check("t3_resp", resp_M, 2);
    tick();
    check("t3_pulse_end", resp_valid_M, 0);
    check("t3_rdata_hold", read_data_M, 32'h1234_5678);
    check("t3_npulse", pulses - p0, 1);

    // 4: write timeout, late B drained
    p0 = pulses;
    AWREADY = 1'b1; WREADY = 1'b1;
    req(1'b1, 32'h0000_5000, 32'h1111_2222);
    tick();
    AWREADY = 1'b0; WREADY = 1'b0;
    tick();
    check("t4_bready", BREADY, 1);
    tick(7);
    check("t4_early", resp_valid_M, 0);
    tick();
    check("t4_pulse", resp_valid_M, 1);
    check("t4_resp", resp_M, 3);
    check("t4_rdata", read_data_M, 0);
    check("t4_ready0", ready_M, 0);
    check("t4_drain_bready", BREADY, 1);
    tick(11);
    check("t4_ready_drain", ready_M, 0);
    check("t4_bready_drain", BREADY, 1);
    check("t4_nopulse", resp_valid_M, 0);
    BVALID = 1'b1; BRESP = 2'b00;
    tick();
    BVALID = 1'b0;
    check("t4_ready1", ready_M, 1);
    check("t4_no2nd", resp_valid_M, 0);
    check("t4_bready_end", BREADY, 0);
    tick();
    check("t4_npulse", pulses - p0, 1);

    // 5: R arrives exactly on the expiry cycle
    p0 = pulses;
    ARREADY = 1'b1;
    req(1'b0, 32'h0000_6000, 32'h0);
    tick();
    ARREADY = 1'b0;
    check("t5_rready", RREADY, 1);
    tick(7);
    check("t5_early", resp_valid_M, 0);
    RVALID = 1'b1; RDATA = 32'hCAFE_F00D; RRESP = 2'b00;
    tick();
    RVALID = 1'b0;
    check("t5_pulse", resp_valid_M, 1);
    check("t5_resp", resp_M, 0);
    check("t5_rdata", read_data_M, 32'hCAFE_F00D);
    check("t5_ready", ready_M, 1);
    tick();
    check("t5_rready_end", RREADY, 0);
    check("t5_npulse", pulses - p0, 1);

    // 6: reset during WR_REQ, then a clean read
    p0 = pulses;
    req(1'b1, 32'h0000_7000, 32'h7777_7777);
    check("t6_awvalid", AWVALID, 1);
    #2 ARESETn = 1'b0;
    #1;
    check("t6_rst_aw", AWVALID, 0);
    check("t6_rst_w", WVALID, 0);
    check("t6_rst_ar", ARVALID, 0);
    check("t6_rst_ready", ready_M, 1);
    check("t6_rst_rvld", resp_valid_M, 0);
    tick(2);
    ARESETn = 1'b1;
    tick();
    check("t6_ready", ready_M, 1);
    check("t6_nopulse", pulses - p0, 0);
    ARREADY = 1'b1;
    req(1'b0, 32'h0000_4000, 32'h0);
    check("t6_araddr", ARADDR, 32'h4000);
    tick();
    ARREADY = 1'b0;
    RVALID = 1'b1; RDATA = 32'h0BAD_F00D; RRESP = 2'b01;
    tick();
    RVALID = 1'b0;
    check("t6_pulse", resp_valid_M, 1);
    check("t6_rdata", read_data_M, 32'h0BAD_F00D);
    check("t6_resp", resp_M, 1);
    tick();
    check("t6_npulse", pulses - p0, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_p.md
Name: axi_lite_master_p

Overview:
Parametrised AXI4-lite master bridge, single clock domain. It converts a simple CPU-side request/response interface into AXI4-lite read and write transactions. It issues AW and W concurrently with independent handshake tracking, drives BREADY/RREADY only while waiting for a response, and returns registered responses. An optional response-timeout watchdog reports DECERR to the requester and drains the late AXI response. Sits between a core/bus-interface unit and the AXI4-lite interconnect.

Parameters:
ADDR_W, 32, AXI and requester address width
DATA_W, 32, AXI and requester data width; must be 32 or 64
STRB_W, DATA_W/8, write strobe width (derived; not overridden)
TIMEOUT, 0, response-wait limit in ACLK cycles; 0 disables the watchdog; max 2^16-1

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AWVALID/AWREADY  out/in  1/1  write address handshake
AWADDR  out  ADDR_W  write address
AWPROT  out  3  write protection
WVALID/WREADY  out/in  1/1  write data handshake
WDATA  out  DATA_W  write data
WSTRB  out  STRB_W  write strobes
BVALID/BREADY  in/out  1/1  write response handshake
BRESP  in  2  write response
ARVALID/ARREADY  out/in  1/1  read address handshake
ARADDR  out  ADDR_W  read address
ARPROT  out  3  read protection
RVALID/RREADY  in/out  1/1  read data handshake
RDATA  in  DATA_W  read data
RRESP  in  2  read response
M_access  in  1  request strobe
ready_M  out  1  block can accept a request
M_rd0_wr1  in  1  0 = read, 1 = write
M_addr  in  ADDR_W  request address
M_prot  in  3  request protection, copied to AxPROT
M_write_data  in  DATA_W  write data
M_write_strobe  in  STRB_W  write strobes
resp_valid_M  out  1  one-cycle completion pulse (read or write)
read_data_M  out  DATA_W  read data, valid with resp_valid_M on reads
resp_M  out  2  AXI response code, valid with resp_valid_M

Behaviour:
- Reset (async, ARESETn low): state IDLE; every AXI VALID/READY = 0; AWADDR/ARADDR/WDATA/WSTRB/xPROT = 0; ready_M = 1; resp_valid_M = 0; read_data_M = 0; resp_M = 0; timer = 0. Reset mid-transaction abandons the transaction without a completion pulse.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DRAIN. ready_M = (state == IDLE), combinational.
- IDLE: M_access=1 latches addr/prot/data/strb into registers. Write -> WR_REQ with AWVALID=WVALID=1 next cycle; read -> RD_REQ with ARVALID=1 next cycle.
- WR_REQ: aw_done/w_done flags. AWVALID = !aw_done; WVALID = !w_done. Each VALID drops the cycle after its own handshake. AW and W may complete in either order or in the same cycle. Exit to WR_RESP the cycle after both are done.
- WR_RESP: BREADY=1. On BVALID -> IDLE; the next cycle resp_valid_M=1 and resp_M=BRESP.
- RD_REQ: ARVALID held until ARREADY -> RD_RESP.
- RD_RESP: RREADY=1. On RVALID -> IDLE; the next cycle resp_valid_M=1, read_data_M=RDATA, resp_M=RRESP. read_data_M holds until the next read completion.
- Payload signals are stable while their VALID is high. VALID never drops before its handshake. The watchdog does not run in REQ states.
- Watchdog (TIMEOUT>0): the timer clears on entry to WR_RESP/RD_RESP and increments each cycle without BVALID/RVALID. At count == TIMEOUT-1 with no response: go to DRAIN; the next cycle resp_valid_M=1, resp_M=2'b11, read_data_M=0.
- DRAIN: BREADY or RREADY is held for the original channel; ready_M=0. On the late BVALID/RVALID the response is discarded (no pulse) -> IDLE.
- A response arriving in the same cycle the timer expires wins: normal completion, no DRAIN.
- End-to-end latency with zero-wait slave: write = 4 cycles from M_access to resp_valid_M; read = 3 cycles.

Decomposition:
- Shared package/defines header: state encodings, AXI response codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), default PROT.
- Sub-module axi_resp_watchdog: timer, clear/enable/expire, parametrised by TIMEOUT; ties expire to 0 when TIMEOUT=0.

Test Plan:
- Write 0x0000_1000 <- 0xDEAD_BEEF, strb 0xF, AWREADY/WREADY both high -> same-cycle AW/W handshake, BRESP=0 -> resp_valid_M pulse 4 cycles after M_access, resp_M=0.
- Write with WREADY 2 cycles before AWREADY -> WVALID drops after its handshake, AWVALID held with stable AWADDR, single B accepted, resp_M=0.
- Read 0x0000_2000, ARREADY delayed 3 cycles, RVALID delayed 5 cycles with RDATA=0x1234_5678, RRESP=2 -> read_data_M=0x1234_5678, resp_M=2, one pulse.
- TIMEOUT=8, write with B withheld 20 cycles -> DECERR pulse after 8 cycles in WR_RESP, ready_M=0 until late B, no second pulse, then ready_M=1.
- TIMEOUT=8, RVALID arrives on the expiry cycle -> normal completion with RDATA, no DRAIN.
- ARESETn pulsed low during WR_REQ -> all VALIDs 0 immediately, ready_M=1, no resp_valid_M; a following read completes normally.
